// File: rtl/bidir_shift_ctrl_pkg.sv
// Shared encodings for the bidirectional shift-register transaction controller.
package bidir_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with synchronous clear; wrap pulses on the enabled N-1 -> 0 edge.
module mod_n_counter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [$clog2(N)-1:0] q,
    output logic                 wrap
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (en)
            q_d = (q_q == LAST) ? '0 : q_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= '0;
        else          q_q <= q_d;
    end

    assign q    = q_q;
    assign wrap = en && (q_q == LAST);

endmodule

// File: rtl/bidir_shift_ctrl.sv
// Word-level controller for an N-bit bidirectional shift register (SI/R_L_n/SO, no enable).
// Optional BIDIR_SHIFT_CTRL_PARITY_EN adds rsp_parity (=^rsp_data, registered with it).
module bidir_shift_ctrl
    import bidir_shift_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_dir,
    input  logic [N-1:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
`ifdef BIDIR_SHIFT_CTRL_PARITY_EN
    output logic         rsp_parity,
`endif
    output logic         sr_si,
    output logic         sr_r_l_n,
    input  logic         sr_so,
    output logic         busy
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(N - 2);

    state_e           state_q, state_d;
    logic [N-1:0]     data_q, data_d;
    logic             dir_q, dir_d;
    logic [N-1:0]     rx_q, rx_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic [CNT_W-1:0] phase, bit_cnt, idx;
    logic             phase_wrap, bit_wrap, accept;

    // Phase tracks idle rotation; it is parked at 0 during SHIFT so RESP starts aligned.
    mod_n_counter #(.N(N)) u_phase (
        .clk(clk), .reset_n(reset_n),
        .clr(state_q == ST_SHIFT), .en(state_q != ST_SHIFT),
        .q(phase), .wrap(phase_wrap)
    );

    mod_n_counter #(.N(N)) u_bit (
        .clk(clk), .reset_n(reset_n),
        .clr(accept), .en(state_q == ST_SHIFT),
        .q(bit_cnt), .wrap(bit_wrap)
    );

    // Accept only on the rotation edge that brings stored contents back into alignment.
    assign accept = req_valid && req_ready_q && phase_wrap;
    assign idx    = (dir_q == DIR_LEFT) ? LAST - bit_cnt : bit_cnt;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        rx_d        = rx_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = req_data;
                    dir_d   = req_dir;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                rx_d[idx] = sr_so;
                if (bit_wrap) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Phase only advances outside SHIFT, so N-2 now means N-1 after this edge.
        req_ready_d = (state_d == ST_IDLE) && (state_q != ST_SHIFT) && (phase == PRE_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            dir_q       <= DIR_RIGHT;
            rx_q        <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            rx_q        <= rx_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef BIDIR_SHIFT_CTRL_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (state_q == ST_SHIFT && bit_wrap)
            parity_d = ^rx_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_q <= 1'b0;
        else          parity_q <= parity_d;
    end

    assign rsp_parity = parity_q;
`endif

    // The register shifts every edge: outside SHIFT it must rotate SO back into SI.
    assign sr_si     = (state_q == ST_SHIFT) ? data_q[idx] : sr_so;
    assign sr_r_l_n  = (state_q == ST_SHIFT) ? dir_q : DIR_RIGHT;
    assign busy      = (state_q == ST_SHIFT);
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rx_q;

endmodule

// File: tb/tb_bidir_shift_ctrl.sv
// Bench: controller wired to a behavioural 4-bit bidirectional shift register, random + directed transfers.
module tb_bidir_shift_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_dir = 1'b0;
    logic [N-1:0] req_data = '0;
    logic         rsp_ready = 1'b0;
    logic         req_ready, rsp_valid, sr_si, sr_r_l_n, sr_so, busy;
    logic [N-1:0] rsp_data;
`ifdef BIDIR_SHIFT_CTRL_PARITY_EN
    logic         rsp_parity;
`endif

    bidir_shift_ctrl #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef BIDIR_SHIFT_CTRL_PARITY_EN
        .rsp_parity(rsp_parity),
`endif
        .sr_si(sr_si), .sr_r_l_n(sr_r_l_n), .sr_so(sr_so), .busy(busy)
    );

    always #5 clk = ~clk;

    // The controlled register: right shift enters at MSB and exits LSB, left is the mirror.
    logic [N-1:0] sr_q;
    assign sr_so = sr_r_l_n ? sr_q[0] : sr_q[N-1];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     sr_q <= '0;
        else if (sr_r_l_n) sr_q <= {sr_si, sr_q[N-1:1]};
        else              sr_q <= {sr_q[N-2:0], sr_si};
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] model_word = '0;   // what the register logically stores

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ready_timing();
        for (int k = 0; k < N; k++) begin
            #1;
            chk("ready_after_reset", req_ready, (k == N - 1));
            if (k < N - 1) @(negedge clk);
        end
    endtask

    // Called at a negedge. Returns previous stored word, then stores d.
    task automatic xfer(input logic [N-1:0] d, input logic dir, input int hold);
        int waited;
        logic [N-1:0] exp_rsp;
        exp_rsp   = model_word;
        waited    = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_dir   = dir;
        while (!req_ready && waited < 3 * N + 4) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        chk("busy_idle", busy, 0);
        chk("rl_idle", sr_r_l_n, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("busy_shift", busy, 1);
            chk("rspv_shift", rsp_valid, 0);
            chk("ready_shift", req_ready, 0);
            chk("rl_shift", sr_r_l_n, dir);
            chk("si_bit", sr_si, dir ? d[k] : d[N-1-k]);
        end
        @(negedge clk);
        model_word = d;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_rsp);
            chk("ready_resp", req_ready, 0);
            chk("busy_resp", busy, 0);
`ifdef BIDIR_SHIFT_CTRL_PARITY_EN
            chk("rsp_parity", rsp_parity, ^exp_rsp);
`endif
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("rspv_cleared", rsp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rl", sr_r_l_n, 1);
        reset_n = 1'b1;
        ready_timing();

        xfer(4'b1011, 1'b1, 0);
        xfer(4'b0110, 1'b0, 7);
        xfer(4'b0001, 1'b1, 0);

        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            xfer(N'($urandom), 1'($urandom), $urandom_range(0, 5));
        end

        // Reset two edges into SHIFT: everything clears and the next response is zero.
        req_valid = 1'b1;
        req_data  = 4'b1100;
        req_dir   = 1'b0;
        for (int w = 0; w < 3 * N && !req_ready; w++) @(negedge clk);
        chk("ready_before_rst", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rspv", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_rl", sr_r_l_n, 1);
        model_word = '0;
        @(negedge clk);
        reset_n = 1'b1;
        ready_timing();
        xfer(N'($urandom), 1'($urandom), 1);

        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            xfer(N'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
